// File: rtl/fpu_pkg.sv
// Shared FPU definitions: storage format, mantissa field layout, status
// encoding and the normalize/round stage state type.
package fpu_pkg;

  localparam int EXP_W    = 6;
  localparam int FRAC_W   = 25;
  localparam int EXP_IN_W = 8;
  localparam int BIAS     = 31;

  // Raw mantissa as produced by the adder SUM step: carry, hidden, fraction, guard, sticky
  localparam int MANT_W    = FRAC_W + 4;
  localparam int M_CARRY   = 28;
  localparam int M_HIDDEN  = 27;
  localparam int M_FRAC_HI = 26;
  localparam int M_FRAC_LO = 2;
  localparam int M_GUARD   = 1;
  localparam int M_STICKY  = 0;

  // One-hot status bit positions
  localparam int ST_EXACT = 0;
  localparam int ST_OVF   = 1;
  localparam int ST_UNF   = 2;
  localparam int ST_INX   = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NORM  = 3'd1,
    S_ROUND = 3'd2,
    S_PACK  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  // Builds the one-hot status word for a given status bit position
  function automatic logic [3:0] status_onehot(input int idx);
    return 4'(1 << idx);
  endfunction

endpackage

// File: rtl/fpu_rne_round.sv
// Round-to-nearest-even on the raw mantissa: increments the fraction LSB
// when the guard bit is set and either sticky or the LSB itself is set.
module fpu_rne_round
  import fpu_pkg::*;
#(
  parameter int MW = MANT_W
) (
  input  logic [MW-1:0] mant,
  output logic [MW-1:0] mant_rounded,
  output logic          round_up,
  output logic          inexact
);

  // Decide the rounding increment and report any discarded precision
  always_comb begin
    round_up     = mant[M_GUARD] & (mant[M_STICKY] | mant[M_FRAC_LO]);
    inexact      = mant[M_GUARD] | mant[M_STICKY];
    mant_rounded = round_up ? (mant + MW'(1 << M_FRAC_LO)) : mant;
  end

endmodule

// File: rtl/fpu_norm_round.sv
// Normalize/round/pack stage after the FPU adder. Normalizes one shift per
// cycle, rounds to nearest-even, classifies zero/overflow/underflow and
// presents the packed word plus one-hot status through valid/ready.
module fpu_norm_round #(
  parameter int EXP_W    = fpu_pkg::EXP_W,
  parameter int FRAC_W   = fpu_pkg::FRAC_W,
  parameter int EXP_IN_W = fpu_pkg::EXP_IN_W,
  parameter int BIAS     = fpu_pkg::BIAS
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sign,
  input  logic signed [EXP_IN_W-1:0] in_exp,
  input  logic [FRAC_W+3:0]          in_mant,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                data_out,
  output logic [3:0]                 status_out
);

  import fpu_pkg::*;

  localparam int MW = FRAC_W + 4;
  localparam logic signed [EXP_IN_W:0] BIAS_X   = (EXP_IN_W+1)'(BIAS);
  localparam logic signed [EXP_IN_W:0] EXP_SAT  = (EXP_IN_W+1)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_IN_W:0] EXP_ZERO = '0;

  state_t state, state_next;

  logic                       sign_q;
  logic signed [EXP_IN_W-1:0] exp_q;
  logic [MW-1:0]              mant_q;
  logic                       zero_q;
  logic                       inexact_q;
  logic [31:0]                data_q;
  logic [3:0]                 status_q;

  logic [MW-1:0]              rnd_mant;
  logic                       rnd_up;
  logic                       rnd_inexact;
  logic signed [EXP_IN_W:0]   biased;

  fpu_rne_round #(.MW(MW)) u_rne (
    .mant         (mant_q),
    .mant_rounded (rnd_mant),
    .round_up     (rnd_up),
    .inexact      (rnd_inexact)
  );

  assign biased     = {exp_q[EXP_IN_W-1], exp_q} + BIAS_X;
  assign in_ready   = (state == S_IDLE);
  assign out_valid  = (state == S_HOLD);
  assign data_out   = data_q;
  assign status_out = status_q;

  // State register; reset abandons whatever operation is in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: stay in NORM while shifting, revisit NORM once after a rounding carry
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          state_next = S_NORM;
        end
      end
      S_NORM: begin
        if (mant_q == '0) begin
          state_next = S_PACK;
        end else if (!mant_q[M_CARRY] && mant_q[M_HIDDEN]) begin
          state_next = S_ROUND;
        end
      end
      S_ROUND: begin
        if (rnd_up && rnd_mant[M_CARRY]) begin
          state_next = S_NORM;
        end else begin
          state_next = S_PACK;
        end
      end
      S_PACK: begin
        state_next = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: capture, single-step normalize, round, then classify and pack the result
  always_ff @(posedge clock) begin
    if (reset) begin
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
      zero_q    <= 1'b0;
      inexact_q <= 1'b0;
      data_q    <= '0;
      status_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sign_q    <= in_sign;
            exp_q     <= in_exp;
            mant_q    <= in_mant;
            zero_q    <= 1'b0;
            inexact_q <= 1'b0;
          end
        end
        S_NORM: begin
          if (mant_q == '0) begin
            zero_q <= 1'b1;
          end else if (mant_q[M_CARRY]) begin
            mant_q <= {1'b0, mant_q[MW-1:2], mant_q[M_GUARD] | mant_q[M_STICKY]};
            exp_q  <= exp_q + EXP_IN_W'(1);
          end else if (!mant_q[M_HIDDEN]) begin
            mant_q <= {mant_q[MW-2:0], 1'b0};
            exp_q  <= exp_q - EXP_IN_W'(1);
          end
        end
        S_ROUND: begin
          mant_q    <= rnd_mant;
          inexact_q <= inexact_q | rnd_inexact;
        end
        S_PACK: begin
          if (zero_q) begin
            data_q   <= 32'h0000_0000;
            status_q <= status_onehot(ST_EXACT);
          end else if (biased >= EXP_SAT) begin
            data_q   <= {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            status_q <= status_onehot(ST_OVF);
          end else if (biased <= EXP_ZERO) begin
            data_q   <= {sign_q, 31'h0};
            status_q <= status_onehot(ST_UNF);
          end else begin
            data_q   <= {sign_q, biased[EXP_W-1:0], mant_q[M_FRAC_HI:M_FRAC_LO]};
            status_q <= inexact_q ? status_onehot(ST_INX) : status_onehot(ST_EXACT);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_norm_round.sv
// Self-checking bench for fpu_norm_round: directed vectors, handshake and
// reset cases, and randomized operands against an arithmetic reference model.
module tb_fpu_norm_round;

  logic              clock;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic signed [7:0] in_exp;
  logic [28:0]       in_mant;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       data_out;
  logic [3:0]        status_out;

  int          checks;
  int          errors;
  bit          pending;
  logic [31:0] exp_data;
  logic [3:0]  exp_status;

  fpu_norm_round dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .status_out (status_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Reference: result word, status and accept-to-valid latency from the stage's rules
  function automatic void model(input bit s, input int e_in, input logic [28:0] m_in,
                                output logic [31:0] d, output logic [3:0] st, output int cyc);
    longint m;
    int     e;
    int     n;
    int     biased;
    bit     inx;
    bit     zero;
    bit     g, sb, l;
    m = longint'(m_in);
    e = e_in;
    n = 0;
    inx = 0;
    zero = 0;
    while (n < 200) begin
      n++;
      if (m == 0) begin
        zero = 1;
        break;
      end
      if (((m >> 28) & 1) != 0) begin
        m = (m >> 1) | (m & 1);
        e = e + 1;
        continue;
      end
      if (((m >> 27) & 1) == 0) begin
        m = m << 1;
        e = e - 1;
        continue;
      end
      n++;
      g  = ((m >> 1) & 1) != 0;
      sb = (m & 1) != 0;
      l  = ((m >> 2) & 1) != 0;
      inx = inx | g | sb;
      if (g && (sb || l)) m = m + 4;
      if (((m >> 28) & 1) != 0) continue;
      break;
    end
    cyc = n + 2;
    biased = e + 31;
    if (zero) begin
      d = 32'h0; st = 4'b0001;
    end else if (biased >= 63) begin
      d = {s, 6'h3F, 25'h0}; st = 4'b0010;
    end else if (biased <= 0) begin
      d = {s, 31'h0}; st = 4'b0100;
    end else begin
      d = {s, 6'(biased), 25'((m >> 2) & 64'h1FF_FFFF)};
      st = inx ? 4'b1000 : 4'b0001;
    end
  endfunction

  // Checks the output bus whenever it is valid, and that nothing appears when no result is owed
  always @(negedge clock) begin
    if (!reset) begin
      if (pending) begin
        if (out_valid) begin
          checkOutput("data_out", data_out, exp_data);
          checkOutput("status_out", 32'(status_out), 32'(exp_status));
          checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
        end
      end else begin
        checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
      end
    end
  end

  // One transaction: model, drive, measure latency, optional backpressure, completion
  task automatic applyStimulus(input bit s, input int e, input logic [28:0] m,
                               input int ready_delay, input bit poke_busy);
    logic [31:0] d;
    logic [3:0]  st;
    int          cyc;
    int          n;
    bit          seen;
    model(s, e, m, d, st, cyc);
    @(negedge clock);
    exp_data   = d;
    exp_status = st;
    in_sign    = s;
    in_exp     = 8'(e);
    in_mant    = m;
    in_valid   = 1'b1;
    out_ready  = (ready_delay == 0);
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    pending = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    n = 1;
    seen = 0;
    while (!seen && n <= 100) begin
      if (out_valid) begin
        seen = 1;
      end else begin
        @(negedge clock);
        n++;
      end
    end
    if (!seen) begin
      checkOutput("out_valid_timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("latency", 32'(n), 32'(cyc));
    end
    if (ready_delay > 0) begin
      if (poke_busy) begin
        in_valid = 1'b1;
        in_sign  = ~s;
        in_exp   = 8'sd3;
        in_mant  = 29'(~m);
      end
      repeat (ready_delay) @(negedge clock);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clock);
    #1 pending = 1'b0;
    @(negedge clock);
    checkOutput("valid_drop", 32'(out_valid), 32'd0);
    checkOutput("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  task automatic pinModel(input string name, input bit s, input int e, input logic [28:0] m,
                          input logic [31:0] d_req, input logic [3:0] st_req, input int cyc_req);
    logic [31:0] d;
    logic [3:0]  st;
    int          cyc;
    model(s, e, m, d, st, cyc);
    checkOutput({name, "_data"}, d, d_req);
    checkOutput({name, "_status"}, 32'(st), 32'(st_req));
    if (cyc_req > 0) checkOutput({name, "_cycles"}, 32'(cyc), 32'(cyc_req));
  endtask

  initial begin
    logic [28:0] rm;
    checks    = 0;
    errors    = 0;
    pending   = 1'b0;
    exp_data  = '0;
    exp_status = '0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b0;

    pinModel("pin_one_plus_one", 0, 0,   29'h1000_0000, 32'h4000_0000, 4'b0001, 5);
    pinModel("pin_round_carry",  0, 0,   29'h0FFF_FFFE, 32'h4000_0000, 4'b1000, 7);
    pinModel("pin_tie_even",     0, 0,   29'h0800_0002, 32'h3E00_0000, 4'b1000, 4);
    pinModel("pin_overflow",     0, 32,  29'h0800_0000, 32'h7E00_0000, 4'b0010, 4);
    pinModel("pin_underflow",    1, -31, 29'h0800_0000, 32'h8000_0000, 4'b0100, 4);
    pinModel("pin_cancel",       0, 0,   29'h0000_0004, 32'h0C00_0000, 4'b0001, 29);
    pinModel("pin_zero",         1, 5,   29'h0,         32'h0000_0000, 4'b0001, 3);

    repeat (3) @(negedge clock);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data_out", data_out, 32'd0);
    checkOutput("rst_status_out", 32'(status_out), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

    applyStimulus(0, 0,   29'h1000_0000, 0, 0);
    applyStimulus(0, 0,   29'h0FFF_FFFE, 0, 0);
    applyStimulus(0, 0,   29'h0800_0002, 0, 0);
    applyStimulus(0, 32,  29'h0800_0000, 0, 0);
    applyStimulus(1, -31, 29'h0800_0000, 0, 0);
    applyStimulus(0, 0,   29'h0000_0004, 0, 0);
    applyStimulus(0, 0,   29'h0,         0, 0);
    applyStimulus(1, 63,  29'h1FFF_FFFF, 0, 0);
    applyStimulus(0, -63, 29'h0000_0001, 0, 0);
    applyStimulus(0, 5,   29'h0A34_5678, 10, 1);

    @(negedge clock);
    in_sign  = 1'b0;
    in_exp   = 8'sd0;
    in_mant  = 29'h0000_0004;
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (5) @(negedge clock);
    checkOutput("mid_norm_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    repeat (40) @(negedge clock);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: rm = 29'($urandom);
        1: rm = 29'($urandom) >> $urandom_range(0, 28);
        2: rm = {2'b01, 27'($urandom)};
        3: rm = {2'b01, 25'h1FF_FFFF, 2'($urandom)};
        default: rm = ($urandom_range(0, 9) == 0) ? 29'h0 : {1'b1, 28'($urandom)};
      endcase
      applyStimulus(1'($urandom), int'($urandom_range(0, 126)) - 63, rm,
                    int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
